// File: rtl/palette_commit_scheduler.sv
// 16-entry 12-bit palette with a small write-request FIFO; queued writes are
// committed to the palette only during vertical blanking, one entry per cycle.
module palette_commit_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int V_ACTIVE   = 480,
    parameter int IDX_W      = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic [IDX_W-1:0] rd_index,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [11:0]      wr_color,
    output logic [3:0]       Red,
    output logic [3:0]       Green,
    output logic [3:0]       Blue,
    output logic             commit_pending,
    output logic             commit_done
);

    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int PAL_DEPTH = 2 ** IDX_W;
    localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE_CNT   = (PW + 1)'(1);
    localparam logic [9:0]  VBLANK_Y  = 10'(V_ACTIVE);

    localparam logic [1:0] ACTIVE    = 2'd0;
    localparam logic [1:0] COMMIT    = 2'd1;
    localparam logic [1:0] DONE_WAIT = 2'd2;

    logic [1:0]       state, state_n;
    logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
    logic [11:0]      fifo_col [FIFO_DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic [11:0]      pal [PAL_DEPTH];
    logic             vblank, full, push, pop, done_n;
    logic             unused_drawx;

    assign unused_drawx   = ^DrawX;
    assign vblank         = (DrawY >= VBLANK_Y);
    assign full           = (count == FULL_CNT);
    assign wr_ready       = !full;
    assign push           = wr_valid && !full;
    assign commit_pending = (count != '0);

    // COMMIT is only ever entered/held with a non-empty FIFO, so a pop there needs no count test.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        done_n  = 1'b0;
        case (state)
            ACTIVE: begin
                if (vblank) state_n = commit_pending ? COMMIT : DONE_WAIT;
            end
            COMMIT: begin
                if (!vblank) begin
                    state_n = ACTIVE;
                    done_n  = 1'b1;
                end else begin
                    pop = 1'b1;
                    if (count == ONE_CNT && !push) begin
                        state_n = DONE_WAIT;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE_WAIT: begin
                if (!vblank) state_n = ACTIVE;
            end
            default: state_n = ACTIVE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_idx[wptr] <= wr_index;
            fifo_col[wptr] <= wr_color;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ACTIVE;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            commit_done <= 1'b0;
            Red         <= '0;
            Green       <= '0;
            Blue        <= '0;
            for (int unsigned i = 0; i < PAL_DEPTH; i++)
                pal[IDX_W'(i)] <= {3{4'(i)}};
        end else begin
            state       <= state_n;
            commit_done <= done_n;
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr                <= rptr + 1'b1;
                pal[fifo_idx[rptr]] <= fifo_col[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Nonblocking read of pal gives read-before-write on a same-cycle commit.
            Red   <= pal[rd_index][11:8];
            Green <= pal[rd_index][7:4];
            Blue  <= pal[rd_index][3:0];
        end
    end

endmodule

// File: tb/tb_palette_commit_scheduler.sv
// Directed, table-driven bench for palette_commit_scheduler.
module tb_palette_commit_scheduler;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [3:0] rd_index = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_index = '0;
    logic [11:0] wr_color = '0;
    logic [3:0] Red, Green, Blue;
    logic       commit_pending, commit_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [11:0] exp;
    } vec_t;

    vec_t ramp_tbl [16];
    vec_t post_tbl [4];

    palette_commit_scheduler #(
        .FIFO_DEPTH(4),
        .V_ACTIVE(480),
        .IDX_W(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .rd_index(rd_index),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_index(wr_index),
        .wr_color(wr_color),
        .Red(Red),
        .Green(Green),
        .Blue(Blue),
        .commit_pending(commit_pending),
        .commit_done(commit_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_rgb(input string name, input logic [11:0] exp);
        chk(name, {20'h0, Red, Green, Blue}, {20'h0, exp});
    endtask

    task automatic read_check(input string name, input logic [3:0] idx, input logic [11:0] exp);
        rd_index = idx;
        tick();
        chk_rgb(name, exp);
    endtask

    task automatic push(input logic [3:0] idx, input logic [11:0] col);
        chk("push_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_index = idx;
        wr_color = col;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ramp_tbl[i].rd  = 4'(i);
            ramp_tbl[i].exp = {3{4'(i)}};
        end
        post_tbl[0] = '{rd: 4'd5, exp: 12'h00F};
        post_tbl[1] = '{rd: 4'd1, exp: 12'h123};
        post_tbl[2] = '{rd: 4'd6, exp: 12'h666};
        post_tbl[3] = '{rd: 4'd2, exp: 12'hABC};

        // Reset state
        DrawY = 10'd100;
        Reset = 1'b1;
        tick();
        chk_rgb("reset_rgb", 12'h000);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_pending", 32'(commit_pending), 32'd0);
        chk("reset_done", 32'(commit_done), 32'd0);
        tick();
        Reset = 1'b0;

        // Reset sweep of the grayscale ramp
        for (int i = 0; i < 16; i++)
            read_check("ramp", ramp_tbl[i].rd, ramp_tbl[i].exp);

        // Deferred commit
        push(4'd3, 12'hF00);
        chk("defer_pending", 32'(commit_pending), 32'd1);
        for (int i = 0; i < 3; i++) begin
            DrawY = 10'(101 + i);
            read_check("defer_active_old", 4'd3, 12'h333);
        end
        DrawY = 10'd480;
        tick();
        chk("defer_done_e0", 32'(commit_done), 32'd0);
        chk_rgb("defer_rgb_e0", 12'h333);
        tick();
        chk("defer_done_e1", 32'(commit_done), 32'd1);
        chk("defer_pending_e1", 32'(commit_pending), 32'd0);
        chk_rgb("defer_rgb_e1", 12'h333);
        tick();
        chk("defer_done_e2", 32'(commit_done), 32'd0);
        chk_rgb("defer_rgb_e2", 12'hF00);
        DrawY = 10'd0;
        tick();
        chk("defer_done_e3", 32'(commit_done), 32'd0);

        // Full FIFO, duplicate index, read/commit collision on idx 2
        DrawY = 10'd100;
        push(4'd5, 12'h0F0);
        push(4'd1, 12'h123);
        push(4'd5, 12'h00F);
        push(4'd2, 12'hABC);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        wr_index = 4'd6;
        wr_color = 12'h555;
        tick();
        wr_valid = 1'b0;
        chk("full_reject_ready", 32'(wr_ready), 32'd0);
        chk("full_pending", 32'(commit_pending), 32'd1);
        rd_index = 4'd2;
        DrawY = 10'd480;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk_rgb("collide_old", 12'h222);
            chk("full_burst_done", 32'(commit_done), (e == 4) ? 32'd1 : 32'd0);
            chk("full_burst_pending", 32'(commit_pending), (e == 4) ? 32'd0 : 32'd1);
        end
        tick();
        chk_rgb("collide_new", 12'hABC);
        chk("full_done_after", 32'(commit_done), 32'd0);
        for (int i = 0; i < 4; i++)
            read_check("full_post", post_tbl[i].rd, post_tbl[i].exp);
        DrawY = 10'd0;
        tick();

        // Burst cut by the active region
        DrawY = 10'd100;
        push(4'd7, 12'h111);
        push(4'd8, 12'h222);
        push(4'd9, 12'h333);
        push(4'd10, 12'h444);
        DrawY = 10'd524;
        tick();
        tick();
        tick();
        chk("cut_done_mid", 32'(commit_done), 32'd0);
        DrawY = 10'd0;
        tick();
        chk("cut_done", 32'(commit_done), 32'd1);
        chk("cut_pending", 32'(commit_pending), 32'd1);
        tick();
        chk("cut_done_off", 32'(commit_done), 32'd0);
        chk("cut_pending_hold", 32'(commit_pending), 32'd1);
        read_check("cut_applied7", 4'd7, 12'h111);
        read_check("cut_applied8", 4'd8, 12'h222);
        read_check("cut_held9", 4'd9, 12'h999);
        read_check("cut_held10", 4'd10, 12'hAAA);
        DrawY = 10'd480;
        tick();
        tick();
        chk("cut2_done_e1", 32'(commit_done), 32'd0);
        tick();
        chk("cut2_done_e2", 32'(commit_done), 32'd1);
        chk("cut2_pending", 32'(commit_pending), 32'd0);
        read_check("cut2_applied9", 4'd9, 12'h333);
        read_check("cut2_applied10", 4'd10, 12'h444);
        DrawY = 10'd0;
        tick();

        // Reset mid-COMMIT
        DrawY = 10'd100;
        push(4'd0, 12'hFFF);
        push(4'd4, 12'h000);
        push(4'd11, 12'hF0F);
        DrawY = 10'd480;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_mid_pending", 32'(commit_pending), 32'd0);
        chk("rst_mid_ready", 32'(wr_ready), 32'd1);
        chk("rst_mid_done", 32'(commit_done), 32'd0);
        chk_rgb("rst_mid_rgb", 12'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid_no_done", 32'(commit_done), 32'd0);
        end
        read_check("rst_ramp0", 4'd0, 12'h000);
        read_check("rst_ramp4", 4'd4, 12'h444);
        read_check("rst_ramp11", 4'd11, 12'hBBB);
        read_check("rst_ramp3", 4'd3, 12'h333);
        DrawY = 10'd0;
        tick();
        DrawY = 10'd480;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_next_no_done", 32'(commit_done), 32'd0);
        end
        read_check("rst_next_ramp4", 4'd4, 12'h444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/palette_commit_scheduler.md
Name: palette_commit_scheduler

Overview:
- Owns the 16-entry, 12-bit palette that drives the HDMI pixel colour output. Decodes a per-pixel palette index into Red/Green/Blue.
- Accepts palette-write requests from the MicroBlaze/AXI side through a small FIFO.
- Commits queued writes to the palette only during vertical blanking, so a frame never changes colour mid-scan.
- Sits between the per-pixel shape/sprite logic, which supplies the index, and the HDMI encoder, which consumes RGB.

Parameters:
- FIFO_DEPTH, 4, write-request queue depth; must be a power of 2, minimum 2.
- V_ACTIVE, 480, first DrawY value treated as vertical blanking.
- IDX_W, 4, palette index width; palette holds 2**IDX_W entries.

Ports:
- Clk  in  1  system/pixel clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column. Informational only; not used for scheduling.
- DrawY  in  10  current pixel row.
- rd_index  in  IDX_W  palette index for the current pixel.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  FIFO can accept a request.
- wr_index  in  IDX_W  palette entry to write.
- wr_color  in  12  {R[3:0],G[3:0],B[3:0]} value to write.
- Red  out  4  registered red.
- Green  out  4  registered green.
- Blue  out  4  registered blue.
- commit_pending  out  1  FIFO non-empty.
- commit_done  out  1  one-cycle pulse when a commit burst ends.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, sampled on the rising edge of Clk.
- Reset values:
  - FIFO empty; wr_ready=1; commit_pending=0; commit_done=0.
  - Red/Green/Blue=0; FSM in ACTIVE.
  - Palette entry i = {i[3:0], i[3:0], i[3:0]}, a grayscale ramp where entry 15 is white.
  - Reset asserted mid-burst discards all queued writes. Palette entries already committed are overwritten by the ramp.
- vblank = (DrawY >= V_ACTIVE). Evaluated combinationally each cycle.
- Write handshake:
  - A request is accepted on a rising edge with wr_valid && wr_ready.
  - wr_ready = !full. A push is refused while full, even if a pop occurs in the same cycle.
  - Accepted requests are committed in strict FIFO order.
  - Duplicate indices are each committed in order, so the last one wins.
- Read path:
  - Red/Green/Blue register palette[rd_index] with 1-cycle latency.
  - Read-before-write: a commit to the same index in the same cycle returns the old value; the new value appears from the next cycle.
- FSM:
  - ACTIVE:
    - If vblank && FIFO non-empty, go to COMMIT.
    - If vblank && FIFO empty, go to DONE_WAIT.
    - Otherwise stay in ACTIVE.
  - COMMIT:
    - Each cycle, pop the FIFO head and write it to the palette. One entry per cycle.
    - Requests pushed during COMMIT are eligible in the same blanking interval.
    - Leave when the FIFO becomes empty after a pop, or when vblank deasserts. In either case pulse commit_done for one cycle.
    - If the FIFO empties, go to DONE_WAIT.
    - If vblank drops with entries remaining, go to ACTIVE. The remaining entries wait for the next vblank.
  - DONE_WAIT:
    - Stay until vblank deasserts, then go to ACTIVE.
    - Writes arriving here are held until the next frame's vblank. This gives at most one commit burst per frame and makes frame boundaries deterministic.
- commit_done fires only on COMMIT exit. It does not fire for a blanking interval with an empty FIFO.
- commit_pending = FIFO count != 0. Registered count, no combinational path from wr_valid.
- Simultaneous push and pop in COMMIT: count unchanged; both take effect.
- FIFO pointers are log2(FIFO_DEPTH) bits wide, wrap naturally, and use a separate count of log2(FIFO_DEPTH)+1 bits.
- DrawY wrap from 524 to 0 ends vblank, handled by the same deassert rule.

Test Plan:
- Reset sweep: after Reset, rd_index=0x7 with DrawY=100 gives Red/Green/Blue=7/7/7 on the next cycle; rd_index=0xF gives F/F/F. Check wr_ready=1 and commit_pending=0.
- Deferred commit: at DrawY=100, write idx 3 = 0xF00. Palette[3] still reads 3/3/3 throughout the active rows. DrawY=480 leads to COMMIT on the next cycle; one cycle later rd_index=3 reads F/0/0 and commit_done pulses once.
- Full FIFO: push 4 writes during the active region. Check wr_ready=0 and that a 5th wr_valid is not accepted. At vblank the 4 entries commit over 4 consecutive cycles in order; with a duplicate idx 5 (0x0F0, then 0x00F), palette[5] ends at 0/0/F.
- Read/commit collision: rd_index=2 in the same cycle that idx 2 = 0xABC commits. Output is 2/2/2, then A/B/C on the following cycle.
- Burst cut by active region: push 4 writes, then DrawY goes 524 to 0 after 2 commit cycles. Exactly 2 entries are applied, commit_done pulses, commit_pending stays 1, and the remaining 2 apply at the next DrawY=480.
- Reset mid-COMMIT: assert Reset with 3 entries queued. The FIFO empties, palette[i] reverts to the ramp, and no commit_done pulse occurs.
